// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit controller.
// Holds the controller state encoding, response error codes, the RISC-V
// load/store funct3 encodings and the default data-memory size.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_BYTES_DEF = 64;

endpackage

// File: rtl/lsu_addr_check.sv
// lsu_addr_check: combinational legality check of a load/store request.
// Ports:
//   ea    - 32-bit effective byte address
//   func3 - RISC-V funct3 of the access
//   we    - 1 = store, 0 = load
//   err   - ERR_OK / ERR_MISALIGN / ERR_RANGE / ERR_ILLEGAL
// Priority is illegal > misaligned > out-of-range.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic [31:0] ea,
  input  logic [2:0]  func3,
  input  logic        we,
  output logic [1:0]  err
);

  logic illegal;
  logic misaligned;
  logic out_of_range;

  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;

    if (we) begin
      illegal = (func3 > F3_W);
    end else begin
      illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
    end

    // func3[1:0] encodes the access size for every legal code
    case (func3[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = |ea[1:0];
      default: misaligned = 1'b0;
    endcase

    out_of_range = (ea >= 32'(MEM_BYTES));

    if (illegal) begin
      err = ERR_ILLEGAL;
    end else if (misaligned) begin
      err = ERR_MISALIGN;
    end else if (out_of_range) begin
      err = ERR_RANGE;
    end else begin
      err = ERR_OK;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between a core and a
// combinational data memory.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_ready            - request handshake
//   req_we, req_func3, req_base,
//   req_offset, req_wdata, req_rd  - request fields (EA = base + offset)
//   resp_valid/resp_ready          - response handshake
//   resp_rdata, resp_rd, resp_err  - load result (extended), echoed tag, error
//   mem_read, mem_write            - memory strobes, high only in ACCESS
//   mem_func3, mem_addr, mem_wdata - access description to memory
//   mem_rdata                      - 32-bit word containing the addressed
//                                    byte, returned in the same cycle
// Stores forward rs2 unshifted; the memory writes its low bytes starting at
// mem_addr according to mem_func3. Loads select the byte lane from the word
// returned by the memory and sign/zero-extend it here.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       ea;
  logic [1:0]        chk_err;
  logic              in_access;

  // Wraps modulo 2^32 by construction of the 32-bit sum
  assign ea = req_base + req_offset;

  lsu_addr_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_addr_check (
    .ea   (ea),
    .func3(req_func3),
    .we   (req_we),
    .err  (chk_err)
  );

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'b0, sh[7:0]};
      F3_HU:   return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign in_access = (state == ACCESS);
  assign req_ready = (state == IDLE);

  // Strobes are gated by rst so a reset landing on ACCESS never touches memory
  assign mem_read  = in_access & ~we_q & ~rst;
  assign mem_write = in_access &  we_q & ~rst;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_func3 = in_access ? func3_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      resp_err   <= ERR_OK;
      we_q       <= 1'b0;
      func3_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        // accept: capture request, decide between memory access and early error
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            func3_q    <= req_func3;
            addr_q     <= ea[ADDR_W-1:0];
            wdata_q    <= req_wdata;
            resp_rd    <= req_rd;
            resp_err   <= chk_err;
            resp_rdata <= '0;
            if (chk_err != ERR_OK) begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state      <= ACCESS;
            end
          end
        end
        // access: one memory cycle, load data captured at its end
        ACCESS: begin
          if (!we_q) begin
            resp_rdata <= load_extend(mem_rdata, addr_q[1:0], func3_q);
          end
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // response: hold until the core takes it
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 64;
  localparam int ADDR_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [31:0]       req_base;
  logic [31:0]       req_offset;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic [1:0]        resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [7:0]  dmem    [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        mem_init;
  int          strobes = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_err;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] v;
    case (i)
      0: v = 32'h05;
      1: v = 32'h02;
      2: v = 32'h00;
      3: v = 32'h02;
      default: v = 32'(i * 37 + 11);
    endcase
    return v[7:0];
  endfunction

  // Memory: returns the aligned word containing mem_addr, writes low bytes of wdata
  always_comb begin
    mem_rdata = {dmem[{mem_addr[5:2], 2'b11}], dmem[{mem_addr[5:2], 2'b10}],
                 dmem[{mem_addr[5:2], 2'b01}], dmem[{mem_addr[5:2], 2'b00}]};
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= init_byte(i);
    end else if (mem_write) begin
      dmem[mem_addr[5:0]] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) dmem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        dmem[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
        dmem[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_read || mem_write) strobes <= strobes + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the access rules stated as plain arithmetic on a byte array
  function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3,
                                           input logic [31:0] ea);
    int size;
    size = 1 << f3[1:0];
    if (we && f3 > 3'd2) return 2'b11;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b11;
    if ((ea % 32'(size)) != 0) return 2'b01;
    if (ea >= 32'(MEM_BYTES)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea);
    int size;
    int base;
    logic [31:0] v;
    size = 1 << f3[1:0];
    base = int'(ea);
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] wd);
    int size;
    logic [31:0] t;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) begin
      t = wd >> (8 * i);
      ref_mem[int'(ea) + i] = t[7:0];
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wdata, input logic [4:0] rd, input int hold);
    logic [31:0] ea;
    logic [1:0]  e;
    logic [31:0] exp_rdata;
    int          s0;
    ea = base + off;
    e = model_err(we, f3, ea);
    exp_rdata = (e == 2'b00 && !we) ? model_load(f3, ea) : 32'h0;

    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_base = base;
    req_offset = off; req_wdata = wdata; req_rd = rd; resp_ready = 1'b0;
    s0 = strobes;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (e != 2'b00) begin
      chk({tag, " resp_valid err lat"}, 32'(resp_valid), 32'd1);
      chk({tag, " no strobe"}, 32'(mem_read | mem_write), 32'd0);
    end else begin
      chk({tag, " resp_valid early"}, 32'(resp_valid), 32'd0);
      chk({tag, " mem_read"}, 32'(mem_read), 32'(!we));
      chk({tag, " mem_write"}, 32'(mem_write), 32'(we));
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(ea[ADDR_W-1:0]));
      chk({tag, " mem_func3"}, 32'(mem_func3), 32'(f3));
      chk({tag, " mem_wdata"}, mem_wdata, wdata);
      @(posedge clk); #1;
      chk({tag, " resp_valid lat"}, 32'(resp_valid), 32'd1);
      chk({tag, " strobe off"}, 32'(mem_read | mem_write), 32'd0);
    end
    chk({tag, " resp_err"}, 32'(resp_err), 32'(e));
    chk({tag, " resp_rdata"}, resp_rdata, exp_rdata);
    chk({tag, " resp_rd"}, 32'(resp_rd), 32'(rd));
    chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
    last_rdata = resp_rdata;
    last_err   = resp_err;

    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_func3 = F3_W; req_base = 32'h0;
        req_offset = 32'h0; req_wdata = 32'hFFFF_FFFF; req_rd = 5'd31;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " hold rdata"}, resp_rdata, exp_rdata);
      chk({tag, " hold err"}, 32'(resp_err), 32'(e));
      chk({tag, " hold rd"}, 32'(resp_rd), 32'(rd));
      chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;

    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
    chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
    chk({tag, " strobe count"}, 32'(strobes - s0), (e == 2'b00) ? 32'd1 : 32'd0);
    if (e == 2'b00 && we) model_store(f3, ea, wdata);
  endtask

  initial begin
    int          s0;
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] rbase;
    logic [31:0] roff;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_base = 32'h0; req_offset = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset strobes", 32'(mem_read | mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    #1;
    chk("post reset req_ready", 32'(req_ready), 32'd1);

    run_req("lw0", 1'b0, F3_W, 32'h0, 32'h0, 32'h0, 5'd3, 0);
    chk("lw0 const", last_rdata, 32'h0200_0205);
    run_req("sw12", 1'b1, F3_W, 32'h8, 32'h4, 32'hDEAD_BEEF, 5'd0, 0);
    run_req("lb12", 1'b0, F3_B, 32'hC, 32'h0, 32'h0, 5'd7, 0);
    chk("lb12 const", last_rdata, 32'hFFFF_FFEF);
    run_req("lbu15", 1'b0, F3_BU, 32'hF, 32'h0, 32'h0, 5'd8, 0);
    chk("lbu15 const", last_rdata, 32'h0000_00DE);
    run_req("lw mis", 1'b0, F3_W, 32'h10, 32'hFFFF_FFF2, 32'h0, 5'd9, 0);
    chk("lw mis const", 32'(last_err), 32'd1);
    run_req("lh wrap", 1'b0, F3_H, 32'hFFFF_FFFE, 32'h4, 32'h0, 5'd10, 0);
    chk("lh wrap const", last_rdata, 32'h0000_0200);
    run_req("sb range", 1'b1, F3_B, 32'd60, 32'h4, 32'h55, 5'd11, 0);
    chk("sb range const", 32'(last_err), 32'd2);
    run_req("ld f3 011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 5'd12, 0);
    chk("ld f3 011 const", 32'(last_err), 32'd3);
    run_req("hold", 1'b0, F3_W, 32'h0, 32'h0, 32'h0, 5'd13, 5);
    run_req("after hold", 1'b0, F3_W, 32'h0, 32'h0, 32'h0, 5'd14, 0);

    // Reset arriving during the ACCESS cycle of a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = F3_W; req_base = 32'h0;
    req_offset = 32'h4; req_wdata = 32'hCAFE_F00D; req_rd = 5'd15;
    s0 = strobes;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst sw in access", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst sw gated", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk("rst sw strobes", 32'(strobes - s0), 32'd0);
    chk("rst sw byte4", 32'(dmem[4]), 32'(ref_mem[4]));
    chk("rst sw idle", 32'(req_ready), 32'd1);
    chk("rst sw resp_valid", 32'(resp_valid), 32'd0);
    chk("rst sw resp_rd", 32'(resp_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst sw ready after", 32'(req_ready), 32'd1);
    run_req("lw4 after rst", 1'b0, F3_W, 32'h0, 32'h4, 32'h0, 5'd16, 0);

    for (int n = 0; n < 40; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      if (n % 8 == 0) begin
        rbase = 32'hFFFF_FFF0;
        roff  = 32'($urandom_range(16, 24));
      end else begin
        rbase = 32'($urandom_range(0, 70));
        roff  = 32'($urandom_range(0, 8)) - 32'd4;
      end
      run_req("rand", rw, rf3, rbase, roff, $urandom, 5'($urandom_range(0, 31)),
              int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, size of the data memory in bytes; legal byte addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have parameter ADDR_W, default 8, width of mem_addr.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_func3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_base  input  32  rs1 value.
REQ-010 req_offset  input  32  sign-extended immediate.
REQ-011 req_wdata  input  32  rs2 store data.
REQ-012 req_rd  input  5  load destination register tag.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  core accepts response.
REQ-015 resp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-016 resp_rd  output  5  echoed req_rd.
REQ-017 resp_err  output  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3.
REQ-018 mem_read, mem_write  output  1 each  data-memory strobes.
REQ-019 mem_func3  output  3  funct3 forwarded to memory.
REQ-020 mem_addr  output  ADDR_W  byte address to memory.
REQ-021 mem_wdata  output  32  store data to memory.
REQ-022 mem_rdata  input  32  combinational read data from memory, valid in the same cycle as mem_read.

Function
REQ-023 FSM states: IDLE, ACCESS, RESP.
REQ-024 IDLE: req_ready=1; on req_valid the block registers all request fields plus EA = req_base+req_offset (32-bit, wrap-around modulo 2^32).
REQ-025 Checks on accept, priority illegal > misaligned > range: illegal = load funct3 in {011,110,111} or store funct3 > 010; misaligned = halfword with EA[0]=1 or word with EA[1:0]!=0; out-of-range = EA >= MEM_BYTES.
REQ-026 Accepted request with no error -> ACCESS; with any error -> RESP directly, with no memory strobe ever asserted.
REQ-027 ACCESS lasts exactly one cycle.
- Drives mem_read=~req_we or mem_write=req_we, mem_addr=EA[ADDR_W-1:0], mem_func3 and mem_wdata from the registered request.
- For loads, registers mem_rdata into resp_rdata.
- Next state RESP.
REQ-028 Outside ACCESS, mem_read=mem_write=0 and mem_addr/mem_wdata/mem_func3 = 0.
REQ-029 RESP: resp_valid=1 with resp_rdata, resp_rd and resp_err held stable until resp_ready=1; that edge returns to IDLE.
REQ-030 Latency: accept at edge N, resp_valid high from edge N+2 (error: N+1); maximum throughput one request per 3 cycles.
REQ-031 req_ready=0 in ACCESS and RESP; req_valid there is ignored and not buffered.
REQ-032 Store responses carry resp_rdata=0 and resp_err=00 on success.

Reset
REQ-033 rst high at an edge forces IDLE and clears resp_valid, resp_rdata, resp_rd, resp_err and all registered request fields to 0.
REQ-034 mem_write and mem_read SHALL be gated by ~rst, so a store in ACCESS during reset never writes memory.
REQ-035 After reset, req_ready=1 in the first cycle rst is low.

Structure
REQ-036 Shared package lsu_pkg holds the state enum, the resp_err codes, the funct3 constants and the MEM_BYTES default.
REQ-037 One sub-module lsu_addr_check (combinational: EA, funct3, we -> err code) is natural; the FSM and registers stay in lsu_ctrl.

Verification
REQ-038 Memory bytes 0..3 = 05,02,00,02; LW base=0 off=0 -> mem_read one cycle, resp_rdata=0x02000205, err=00, resp_valid at accept+2.
REQ-039 SW base=8 off=4 wdata=0xDEADBEEF, then LB at 12 -> 0xFFFFFFEF; LBU at 15 -> 0x000000DE.
REQ-040 LW base=0x10 off=-14 (EA=2) -> err=01, no mem strobe, resp_valid at accept+1, rdata=0.
REQ-041 LH base=0xFFFFFFFE off=4 (EA wraps to 2) -> err=00; SB at EA=64 -> err=10; funct3=011 load -> err=11.
REQ-042 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; a req_valid pulse meanwhile is dropped.
REQ-043 Assert rst in the ACCESS cycle of SW to address 4 -> mem_write=0 at that edge, byte 4 unchanged, IDLE next cycle.
